// File: rtl/trng_pkg.sv
// trng_pkg: shared constants and helpers for the TRNG register bank.
// Holds register byte offsets, CTRL/STATUS bit positions, the entropy
// word width and a register-offset decode function.
package trng_pkg;

    localparam int TRNG_WORD_W = 32;

    // Register byte offsets.
    localparam logic [11:0] OFF_CTRL      = 12'h000;
    localparam logic [11:0] OFF_STATUS    = 12'h004;
    localparam logic [11:0] OFF_DATA      = 12'h008;
    localparam logic [11:0] OFF_REP_LIMIT = 12'h00C;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // STATUS bit positions.
    localparam int ST_EMPTY_BIT   = 0;
    localparam int ST_FULL_BIT    = 1;
    localparam int ST_OVF_BIT     = 2;
    localparam int ST_REPFAIL_BIT = 3;
    localparam int ST_LEVEL_LSB   = 16;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_DATA,
        REG_REP_LIMIT,
        REG_NONE
    } reg_sel_e;

    // Map a word-aligned byte offset onto a register; unmapped offsets give REG_NONE.
    function automatic reg_sel_e decode_reg(input logic [31:0] byte_off);
        reg_sel_e sel;
        case (byte_off)
            {20'h00000, OFF_CTRL}:      sel = REG_CTRL;
            {20'h00000, OFF_STATUS}:    sel = REG_STATUS;
            {20'h00000, OFF_DATA}:      sel = REG_DATA;
            {20'h00000, OFF_REP_LIMIT}: sel = REG_REP_LIMIT;
            default:                    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: synchronous first-word-fall-through FIFO for entropy words.
// Ports: i_clk/i_rst (async active-high), i_push/i_push_data, i_pop,
// i_flush (synchronous clear), o_head (current head word), o_full,
// o_empty, o_level (occupancy, one bit wider than the pointers).
// A push while full is accepted only when a pop frees a slot the same cycle;
// a pop while empty is ignored.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = TRNG_WORD_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == {LVL_W{1'b0}});
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; flush overrides any push/pop in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/trng_bram_regbank.sv
// trng_bram_regbank: register bank and entropy word buffer behind the
// BRAM-style port of the TRNG AXI4-Lite slave.
// Ports: bram_clk_a/bram_rst_a (async active-high), bram_en_a, bram_we_a,
// bram_addr_a, bram_wrdata_a, bram_rddata_a (registered, 1-cycle latency),
// entropy_bit/entropy_valid (raw noise), fifo_level (FIFO occupancy).
// Registers: CTRL (EN, FLUSH), STATUS (EMPTY, FULL, OVF, REPFAIL, level),
// DATA (pops FIFO head), REP_LIMIT (repetition-count threshold, 0 = off).
module trng_bram_regbank
    import trng_pkg::*;
#(
    parameter int ADDR_WIDTH    = 13,
    parameter int FIFO_DEPTH    = 16,
    parameter int REP_LIMIT_RST = 32
) (
    input  logic                          bram_clk_a,
    input  logic                          bram_rst_a,
    input  logic                          bram_en_a,
    input  logic [3:0]                    bram_we_a,
    input  logic [ADDR_WIDTH-1:0]         bram_addr_a,
    input  logic [31:0]                   bram_wrdata_a,
    output logic [31:0]                   bram_rddata_a,
    input  logic                          entropy_bit,
    input  logic                          entropy_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             r_en;
    logic             r_ovf;
    logic             r_repfail;
    logic [7:0]       r_rep_limit;
    logic [31:0]      r_shift;
    logic [4:0]       r_bitcnt;
    logic [7:0]       r_run_len;
    logic             r_last_bit;
    logic [31:0]      r_rddata;

    logic [31:0]      w_byte_off;
    reg_sel_e         w_sel;
    logic             w_wr_b0;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic             w_st_wr;
    logic             w_replim_wr;
    logic             w_flush;
    logic             w_pop;
    logic             w_accept;
    logic [7:0]       w_run_next;
    logic             w_rep_hit;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_repfail_clr;
    logic [31:0]      w_word;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_val;
    logic [31:0]      w_fifo_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [LVL_W-1:0] w_fifo_level;
    logic             w_unused;

    assign w_unused = ^{bram_addr_a[1:0], bram_wrdata_a[31:8]};

    // Register decode; only byte lane 0 carries writable bits.
    assign w_byte_off    = 32'({bram_addr_a[ADDR_WIDTH-1:2], 2'b00});
    assign w_sel         = decode_reg(w_byte_off);
    assign w_wr_b0       = bram_en_a && (bram_we_a != 4'b0000) && bram_we_a[0];
    assign w_rd          = bram_en_a && (bram_we_a == 4'b0000);
    assign w_ctrl_wr     = w_wr_b0 && (w_sel == REG_CTRL);
    assign w_st_wr       = w_wr_b0 && (w_sel == REG_STATUS);
    assign w_replim_wr   = w_wr_b0 && (w_sel == REG_REP_LIMIT);
    assign w_flush       = w_ctrl_wr && bram_wrdata_a[CTRL_FLUSH_BIT];
    assign w_pop         = w_rd && (w_sel == REG_DATA) && !w_fifo_empty;
    assign w_repfail_clr = w_st_wr && bram_wrdata_a[ST_REPFAIL_BIT] && r_repfail;

    // Packer and health test: bits enter at the MSB and shift right,
    // so the first accepted bit ends up at bit 0 of the completed word.
    assign w_accept  = r_en && entropy_valid && !r_repfail;
    assign w_word    = {entropy_bit, r_shift[31:1]};
    assign w_rep_hit = w_accept && (r_rep_limit != 8'd0) && (w_run_next >= r_rep_limit);
    assign w_push    = w_accept && !w_rep_hit && (r_bitcnt == 5'd31) && !w_flush;
    assign w_ovf_set = w_push && w_fifo_full && !w_pop;

    // Run length including the current bit; saturates so a disabled test cannot wrap.
    always_comb begin
        w_run_next = r_run_len;
        if ((r_run_len == 8'd0) || (entropy_bit != r_last_bit)) begin
            w_run_next = 8'd1;
        end else if (r_run_len != 8'hFF) begin
            w_run_next = r_run_len + 8'd1;
        end else begin
            w_run_next = r_run_len;
        end
    end

    // Shift register, bit counter and run tracker.
    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_shift    <= 32'd0;
            r_bitcnt   <= 5'd0;
            r_run_len  <= 8'd0;
            r_last_bit <= 1'b0;
        end else if (w_flush) begin
            r_shift    <= 32'd0;
            r_bitcnt   <= 5'd0;
            r_run_len  <= 8'd0;
            r_last_bit <= 1'b0;
        end else if (w_rep_hit) begin
            r_shift    <= 32'd0;
            r_bitcnt   <= 5'd0;
            r_run_len  <= w_run_next;
            r_last_bit <= entropy_bit;
        end else if (w_accept) begin
            r_shift    <= w_word;
            r_bitcnt   <= r_bitcnt + 5'd1;
            r_run_len  <= w_run_next;
            r_last_bit <= entropy_bit;
        end else if (w_repfail_clr) begin
            r_run_len  <= 8'd0;
        end else begin
            r_run_len  <= r_run_len;
        end
    end

    // Control and sticky status registers; a new event beats a W1C in the same cycle.
    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_en        <= 1'b0;
            r_ovf       <= 1'b0;
            r_repfail   <= 1'b0;
            r_rep_limit <= 8'(REP_LIMIT_RST);
        end else begin
            if (w_ctrl_wr) begin
                r_en <= bram_wrdata_a[CTRL_EN_BIT];
            end
            if (w_replim_wr) begin
                r_rep_limit <= bram_wrdata_a[7:0];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_st_wr && bram_wrdata_a[ST_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_rep_hit) begin
                r_repfail <= 1'b1;
            end else if (w_st_wr && bram_wrdata_a[ST_REPFAIL_BIT]) begin
                r_repfail <= 1'b0;
            end else begin
                r_repfail <= r_repfail;
            end
        end
    end

    // Read mux; values reflect state before this edge's updates.
    always_comb begin
        w_status = 32'd0;
        w_status[ST_EMPTY_BIT]             = w_fifo_empty;
        w_status[ST_FULL_BIT]              = w_fifo_full;
        w_status[ST_OVF_BIT]               = r_ovf;
        w_status[ST_REPFAIL_BIT]           = r_repfail;
        w_status[ST_LEVEL_LSB +: LVL_W]    = w_fifo_level;
        case (w_sel)
            REG_CTRL:      w_rd_val = {31'd0, r_en};
            REG_STATUS:    w_rd_val = w_status;
            REG_DATA:      w_rd_val = w_fifo_empty ? 32'd0 : w_fifo_head;
            REG_REP_LIMIT: w_rd_val = {24'd0, r_rep_limit};
            default:       w_rd_val = 32'd0;
        endcase
    end

    // Read data register; holds between reads.
    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_rddata <= 32'd0;
        end else if (w_rd) begin
            r_rddata <= w_rd_val;
        end else begin
            r_rddata <= r_rddata;
        end
    end

    assign bram_rddata_a = r_rddata;
    assign fifo_level    = w_fifo_level;

    trng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRNG_WORD_W)
    ) u_fifo (
        .i_clk       (bram_clk_a),
        .i_rst       (bram_rst_a),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_fifo_level)
    );

endmodule
